// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : Central pipeline sequencer for the 5-stage core. Drives    |
// |               stall/flush controls for pc and the four pipeline          |
// |               registers from load-use detection, taken-branch redirect   |
// |               and data-memory wait. Tracks stalled cycles in a           |
// |               saturating counter and flags memory timeouts.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int REDIRECT_BUBBLES = 2,   // cycles if_id_flush is held after a taken branch (>=1)
   parameter int MEM_TIMEOUT      = 64,  // consecutive MEM_WAIT cycles before mem_err sets
   parameter int CNT_W            = 16   // width of stall_cnt
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_flush,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_err
);

   // Redirect counter only has to hold REDIRECT_BUBBLES-1; keep at least 1 bit.
   localparam int RCNT_W = (REDIRECT_BUBBLES > 2) ? $clog2(REDIRECT_BUBBLES) : 1;
   // Wait counter saturates at MEM_TIMEOUT, so it must be able to represent it.
   localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [RCNT_W-1:0] C_RCNT_LOAD = RCNT_W'(REDIRECT_BUBBLES - 1);
   localparam logic [RCNT_W-1:0] C_RCNT_ONE  = RCNT_W'(1);
   localparam logic [WCNT_W-1:0] C_WCNT_MAX  = WCNT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   // Registered state
   state_t              r_state;
   logic                r_ret_redirect;   // MEM_WAIT returns to REDIRECT when set
   logic [RCNT_W-1:0]   r_redir_cnt;
   logic [WCNT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic                r_mem_err;

   // Next-state values
   state_t              w_state_n;
   logic                w_ret_redirect_n;
   logic [RCNT_W-1:0]   w_redir_cnt_n;
   logic [WCNT_W-1:0]   w_wait_cnt_n;
   logic                w_err_set;

   // Hazard conditions
   logic                w_mem_hold;
   logic                w_load_use;
   logic                w_rs1_hit;
   logic                w_rs2_hit;
   logic [WCNT_W-1:0]   w_wait_inc;

   // Memory hold covers both a fresh miss and an already-waiting access.
   assign w_mem_hold = (r_state == ST_MEM_WAIT) | (mem_req & ~mem_ready);

   assign w_rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
   assign w_rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
   // x0 is never a real producer, so a load into it cannot create a hazard.
   assign w_load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

   // Saturating increment so a very long wait cannot wrap past the threshold.
   assign w_wait_inc = (r_wait_cnt == C_WCNT_MAX) ? r_wait_cnt : (r_wait_cnt + 1'b1);

   // Next-state and control outputs, resolved in priority order.
   always_comb begin
      w_state_n        = r_state;
      w_ret_redirect_n = r_ret_redirect;
      w_redir_cnt_n    = r_redir_cnt;
      w_wait_cnt_n     = r_wait_cnt;
      w_err_set        = 1'b0;
      pc_stall         = 1'b0;
      if_id_stall      = 1'b0;
      if_id_flush      = 1'b0;
      id_ex_stall      = 1'b0;
      id_ex_flush      = 1'b0;
      ex_mem_stall     = 1'b0;
      mem_wb_flush     = 1'b0;

      if (rst) begin
         // All controls idle; state is cleared by the register block.
      end else if (w_mem_hold) begin
         // Freeze everything up to EX/MEM and bubble MEM/WB. Branch and
         // load-use are ignored here: EX is frozen so they come back later.
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
         case (r_state)
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  w_state_n    = r_ret_redirect ? ST_REDIRECT : ST_RUN;
                  w_wait_cnt_n = '0;
               end else begin
                  w_wait_cnt_n = w_wait_inc;
                  if (w_wait_inc == C_WCNT_MAX) begin
                     w_err_set = 1'b1;
                  end
               end
            end
            ST_REDIRECT: begin
               // Redirect count stays frozen while the memory wait runs.
               w_state_n        = ST_MEM_WAIT;
               w_ret_redirect_n = 1'b1;
               w_wait_cnt_n     = '0;
            end
            default: begin
               w_state_n        = ST_MEM_WAIT;
               w_ret_redirect_n = 1'b0;
               w_wait_cnt_n     = '0;
            end
         endcase
      end else if (ex_branch_taken) begin
         // First redirect cycle kills both the fetched and decoded instructions.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         if (REDIRECT_BUBBLES > 1) begin
            w_state_n     = ST_REDIRECT;
            w_redir_cnt_n = C_RCNT_LOAD;
         end else begin
            w_state_n     = ST_RUN;
            w_redir_cnt_n = '0;
         end
      end else if (r_state == ST_REDIRECT) begin
         // Remaining redirect bubbles only kill the fetch slot.
         if_id_flush = 1'b1;
         if (r_redir_cnt <= C_RCNT_ONE) begin
            w_state_n     = ST_RUN;
            w_redir_cnt_n = '0;
         end else begin
            w_redir_cnt_n = r_redir_cnt - 1'b1;
         end
      end else if ((r_state == ST_RUN) && w_load_use) begin
         // One-cycle bubble: hold fetch/decode, inject a nop into EX.
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end else if (r_state != ST_RUN) begin
         // Unused encoding: recover to RUN.
         w_state_n = ST_RUN;
      end
   end

   // State register for the sequencer FSM and its counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_ret_redirect <= 1'b0;
         r_redir_cnt    <= '0;
         r_wait_cnt     <= '0;
      end else begin
         r_state        <= w_state_n;
         r_ret_redirect <= w_ret_redirect_n;
         r_redir_cnt    <= w_redir_cnt_n;
         r_wait_cnt     <= w_wait_cnt_n;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   // Sticky memory-timeout flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_err <= 1'b0;
      end else if (w_err_set) begin
         r_mem_err <= 1'b1;
      end
   end

   assign hz_state  = r_state;
   assign stall_cnt = r_stall_cnt;
   assign mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Scoreboard bench for hazard_ctrl. Directed vectors push    |
// |               their hand-computed expected response into a queue; a      |
// |               monitor pops and compares on every falling edge.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

   localparam int CNT_W = 6;

   // Control word bit order: {pc, if_id_stall, if_id_flush, id_ex_stall,
   // id_ex_flush, ex_mem_stall, mem_wb_flush}
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LU   = 7'b1100100;
   localparam logic [6:0] C_BR   = 7'b0010100;
   localparam logic [6:0] C_RD   = 7'b0010000;
   localparam logic [6:0] C_MW   = 7'b1101011;

   // Flag word: {rst, ex_branch_taken, mem_req, mem_ready}
   localparam logic [3:0] F_IDLE = 4'b0000;
   localparam logic [3:0] F_RST  = 4'b1000;
   localparam logic [3:0] F_BR   = 4'b0100;
   localparam logic [3:0] F_WAIT = 4'b0010;
   localparam logic [3:0] F_DONE = 4'b0011;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic             ex_valid = 1'b0, ex_mem_read = 1'b0;
   logic             ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall;
   logic             id_ex_flush, ex_mem_stall, mem_wb_flush;
   logic [1:0]       hz_state;
   logic [CNT_W-1:0] stall_cnt;
   logic             mem_err;

   hazard_ctrl #(
      .REDIRECT_BUBBLES (2),
      .MEM_TIMEOUT      (4),
      .CNT_W            (CNT_W)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_valid        (ex_valid),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .if_id_flush     (if_id_flush),
      .id_ex_stall     (id_ex_stall),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_stall    (ex_mem_stall),
      .mem_wb_flush    (mem_wb_flush),
      .hz_state        (hz_state),
      .stall_cnt       (stall_cnt),
      .mem_err         (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               idx;
      logic [6:0]       ctl;
      logic [1:0]       st;
      logic [CNT_W-1:0] cnt;
      logic             err;
      logic             chk;   // registered outputs are meaningful this cycle
   } exp_t;

   exp_t             sb[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   int               vec_idx = 0;
   logic [CNT_W-1:0] m_cnt = '0;   // expected stall_cnt, from expected pc_stall

   // Apply one cycle of stimulus and queue its expected response.
   task automatic vec(input logic [3:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [3:0] lu, input logic [6:0] ctl,
                      input logic [1:0] st, input logic err, input logic chk);
      exp_t e;
      @(posedge clk);
      #1;
      {rst, ex_branch_taken, mem_req, mem_ready} = f;
      ex_rd  = rd;
      id_rs1 = rs1;
      id_rs2 = rs2;
      {ex_valid, ex_mem_read, id_use_rs1, id_use_rs2} = lu;
      e.idx = vec_idx;
      e.ctl = ctl;
      e.st  = st;
      e.cnt = m_cnt;
      e.err = err;
      e.chk = chk;
      sb.push_back(e);
      vec_idx++;
      if (f[3])
         m_cnt = '0;
      else if (ctl[6] && (m_cnt != {CNT_W{1'b1}}))
         m_cnt = m_cnt + 1'b1;
   endtask

   task automatic flags(input logic [3:0] f, input logic [6:0] ctl, input logic [1:0] st,
                        input logic err);
      vec(f, 5'd0, 5'd0, 5'd0, 4'b0000, ctl, st, err, 1'b1);
   endtask

   // Monitor: every falling edge with a pending expectation is one response.
   initial begin
      exp_t e;
      logic [6:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, mem_wb_flush};
            n_cmp++;
            if (act !== e.ctl) begin
               n_bad++;
               $display("FAIL v%0d controls: got %b want %b", e.idx, act, e.ctl);
            end
            if (e.chk) begin
               n_cmp++;
               if (hz_state !== e.st) begin
                  n_bad++;
                  $display("FAIL v%0d hz_state: got %0d want %0d", e.idx, hz_state, e.st);
               end
               n_cmp++;
               if (stall_cnt !== e.cnt) begin
                  n_bad++;
                  $display("FAIL v%0d stall_cnt: got %0d want %0d", e.idx, stall_cnt, e.cnt);
               end
               n_cmp++;
               if (mem_err !== e.err) begin
                  n_bad++;
                  $display("FAIL v%0d mem_err: got %0d want %0d", e.idx, mem_err, e.err);
               end
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      int drain;
      // Reset held two cycles with a pending memory miss.
      vec(F_RST | F_WAIT, 5'd0, 5'd0, 5'd0, 4'b0000, C_NONE, 2'd0, 1'b0, 1'b0);
      vec(F_RST | F_WAIT, 5'd0, 5'd0, 5'd0, 4'b0000, C_NONE, 2'd0, 1'b0, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);

      // Load-use on rs2, then on rs1, plus non-hazard variants.
      vec(F_IDLE, 5'd5, 5'd0, 5'd5, 4'b1101, C_LU,   2'd0, 1'b0, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);
      vec(F_IDLE, 5'd0, 5'd0, 5'd0, 4'b1101, C_NONE, 2'd0, 1'b0, 1'b1);
      vec(F_IDLE, 5'd7, 5'd7, 5'd0, 4'b1110, C_LU,   2'd0, 1'b0, 1'b1);
      vec(F_IDLE, 5'd7, 5'd7, 5'd0, 4'b1100, C_NONE, 2'd0, 1'b0, 1'b1);
      vec(F_IDLE, 5'd7, 5'd7, 5'd0, 4'b0110, C_NONE, 2'd0, 1'b0, 1'b1);
      vec(F_IDLE, 5'd7, 5'd7, 5'd0, 4'b1010, C_NONE, 2'd0, 1'b0, 1'b1);
      vec(F_IDLE, 5'd7, 5'd0, 5'd3, 4'b1111, C_NONE, 2'd0, 1'b0, 1'b1);

      // Taken branch; load-use during the redirect bubble is ignored.
      flags(F_BR, C_BR, 2'd0, 1'b0);
      vec(F_IDLE, 5'd5, 5'd0, 5'd5, 4'b1101, C_RD, 2'd2, 1'b0, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);

      // Memory wait with a branch and load-use held in EX the whole time.
      vec(F_BR | F_WAIT, 5'd5, 5'd0, 5'd5, 4'b1101, C_MW, 2'd0, 1'b0, 1'b1);
      flags(F_BR | F_WAIT, C_MW, 2'd1, 1'b0);
      flags(F_BR | F_WAIT, C_MW, 2'd1, 1'b0);
      flags(F_BR | F_DONE, C_MW, 2'd1, 1'b0);
      flags(F_BR, C_BR, 2'd0, 1'b0);
      flags(F_IDLE, C_RD, 2'd2, 1'b0);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);
      // Request completing in the same cycle causes no hold.
      flags(F_DONE, C_NONE, 2'd0, 1'b0);

      // Memory wait arriving during redirect freezes and resumes it.
      flags(F_BR, C_BR, 2'd0, 1'b0);
      flags(F_WAIT, C_MW, 2'd2, 1'b0);
      flags(F_WAIT, C_MW, 2'd1, 1'b0);
      flags(F_DONE, C_MW, 2'd1, 1'b0);
      flags(F_IDLE, C_RD, 2'd2, 1'b0);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);

      // Back-to-back branches reload the redirect count.
      flags(F_BR, C_BR, 2'd0, 1'b0);
      flags(F_BR, C_BR, 2'd2, 1'b0);
      flags(F_IDLE, C_RD, 2'd2, 1'b0);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);

      // Timeout after four MEM_WAIT cycles; flag is sticky.
      flags(F_WAIT, C_MW, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) flags(F_WAIT, C_MW, 2'd1, 1'b0);
      flags(F_WAIT, C_MW, 2'd1, 1'b1);
      flags(F_DONE, C_MW, 2'd1, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b1);

      // Long wait drives stall_cnt into saturation.
      flags(F_WAIT, C_MW, 2'd0, 1'b1);
      for (int i = 0; i < 49; i++) flags(F_WAIT, C_MW, 2'd1, 1'b1);
      flags(F_DONE, C_MW, 2'd1, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b1);

      // Reset in the middle of a memory wait.
      flags(F_WAIT, C_MW, 2'd0, 1'b1);
      flags(F_WAIT, C_MW, 2'd1, 1'b1);
      flags(F_RST | F_WAIT, C_NONE, 2'd1, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);

      // Reset in the middle of a redirect.
      flags(F_BR, C_BR, 2'd0, 1'b0);
      flags(F_RST, C_NONE, 2'd2, 1'b0);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);
      vec(F_IDLE, 5'd9, 5'd9, 5'd0, 4'b1110, C_LU, 2'd0, 1'b0, 1'b1);
      flags(F_IDLE, C_NONE, 2'd0, 1'b0);

      // Let the monitor consume the remaining expectations, bounded.
      drain = 0;
      while ((sb.size() > 0) && (drain < 10)) begin
         @(posedge clk);
         drain++;
      end
      if (sb.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
